// File: rtl/vx_sleep_ctrl.sv
// vx_sleep_ctrl: core sleep/wake sequencer that drains outstanding cache traffic before gating.
// Optional build macro SLEEP_CTRL_PERF_EN adds sleep-cycle and sleep-entry counters.
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif

module vx_sleep_ctrl #(
  parameter int CORE_ID    = 0,
  parameter int WAKE_DELAY = 4,
  parameter int PEND_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sleep_req_i,
  input  logic                    wakeup_i,
  input  logic [`NUM_THREADS-1:0] dcache_req_valid_i,
  input  logic [`NUM_THREADS-1:0] dcache_req_ready_i,
  input  logic                    dcache_rsp_valid_i,
  input  logic [`NUM_THREADS-1:0] dcache_rsp_tmask_i,
  input  logic                    dcache_rsp_ready_i,
  input  logic                    icache_req_valid_i,
  input  logic                    icache_req_ready_i,
  input  logic                    icache_rsp_valid_i,
  input  logic                    icache_rsp_ready_i,
  output logic                    fetch_block_o,
  output logic                    clk_en_o,
  output logic                    sleeping_o,
  output logic                    wake_ack_o
`ifdef SLEEP_CTRL_PERF_EN
  ,
  output logic [63:0]             perf_sleep_cycles_o,
  output logic [31:0]             perf_sleep_entries_o
`endif
);

  localparam int NT = `NUM_THREADS;
  localparam int CW = PEND_WIDTH + $clog2(NT + 1) + 1;
  localparam logic [CW-1:0] PEND_MAX = (CW'(1) << PEND_WIDTH) - CW'(1);
  localparam logic [7:0] WAKE_LOAD = 8'(WAKE_DELAY - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SLEEP = 2'd2,
    ST_WAKE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_sleep_q;
  logic [7:0]            r_wake_cnt;
  logic                  r_wake_ack;
  logic [PEND_WIDTH-1:0] r_dpend;
  logic [PEND_WIDTH-1:0] r_ipend;

  logic [NT-1:0]         w_d_req_fire;
  logic [NT-1:0]         w_d_rsp_bits;
  logic                  w_d_rsp_fire;
  logic                  w_i_req_fire;
  logic                  w_i_rsp_fire;
  logic [CW-1:0]         w_d_inc;
  logic [CW-1:0]         w_d_dec;
  logic [CW-1:0]         w_d_sum;
  logic [CW-1:0]         w_d_diff;
  logic                  w_dpend_unf;
  logic                  w_dpend_ovf;
  logic [PEND_WIDTH-1:0] w_dpend_next;
  logic                  w_ipend_unf;
  logic                  w_ipend_ovf;
  logic [PEND_WIDTH-1:0] w_ipend_next;
  logic                  w_sleep_edge;
  logic                  w_any_fire;
  logic                  w_drained;

  assign w_d_rsp_fire = dcache_rsp_valid_i & dcache_rsp_ready_i;
  assign w_i_req_fire = icache_req_valid_i & icache_req_ready_i;
  assign w_i_rsp_fire = icache_rsp_valid_i & icache_rsp_ready_i;

  generate
    for (genvar gi = 0; gi < NT; gi++) begin : g_thread
      assign w_d_req_fire[gi] = dcache_req_valid_i[gi] & dcache_req_ready_i[gi];
      assign w_d_rsp_bits[gi] = dcache_rsp_tmask_i[gi] & w_d_rsp_fire;
    end
  endgenerate

  always_comb begin
    w_d_inc = '0;
    w_d_dec = '0;
    for (int i = 0; i < NT; i++) begin
      w_d_inc = w_d_inc + CW'(w_d_req_fire[i]);
      w_d_dec = w_d_dec + CW'(w_d_rsp_bits[i]);
    end
  end

  // Net change is computed in a wider domain so both saturation limits are visible.
  always_comb begin
    w_d_sum     = CW'(r_dpend) + w_d_inc;
    w_d_diff    = w_d_sum - w_d_dec;
    w_dpend_unf = (w_d_sum < w_d_dec);
    w_dpend_ovf = !w_dpend_unf && (w_d_diff > PEND_MAX);
    if (w_dpend_unf) begin
      w_dpend_next = '0;
    end else if (w_dpend_ovf) begin
      w_dpend_next = '1;
    end else begin
      w_dpend_next = w_d_diff[PEND_WIDTH-1:0];
    end
  end

  always_comb begin
    w_ipend_unf  = (r_ipend == '0) && w_i_rsp_fire && !w_i_req_fire;
    w_ipend_ovf  = (r_ipend == '1) && w_i_req_fire && !w_i_rsp_fire;
    w_ipend_next = r_ipend;
    if (w_i_req_fire && !w_i_rsp_fire && !w_ipend_ovf) begin
      w_ipend_next = r_ipend + 1'b1;
    end else if (w_i_rsp_fire && !w_i_req_fire && !w_ipend_unf) begin
      w_ipend_next = r_ipend - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dpend   <= '0;
      r_ipend   <= '0;
      r_sleep_q <= 1'b0;
    end else begin
      r_dpend   <= w_dpend_next;
      r_ipend   <= w_ipend_next;
      r_sleep_q <= sleep_req_i;
    end
  end

  assign w_sleep_edge = sleep_req_i & ~r_sleep_q;
  assign w_any_fire   = (|w_d_req_fire) | w_d_rsp_fire | w_i_req_fire | w_i_rsp_fire;
  assign w_drained    = (r_dpend == '0) && (r_ipend == '0) && !w_any_fire;

  // State register, wake countdown and the post-wake acknowledge flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_wake_cnt <= '0;
      r_wake_ack <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wake_ack <= (r_state == ST_WAKE) && (w_state_next == ST_RUN);
      if ((r_state == ST_SLEEP) && wakeup_i) begin
        r_wake_cnt <= WAKE_LOAD;
      end else if ((r_state == ST_WAKE) && (r_wake_cnt != '0)) begin
        r_wake_cnt <= r_wake_cnt - 8'd1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_sleep_edge && !wakeup_i) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (wakeup_i) begin
          w_state_next = ST_RUN;
        end else if (w_drained) begin
          w_state_next = ST_SLEEP;
        end
      end
      ST_SLEEP: begin
        if (wakeup_i) begin
          w_state_next = ST_WAKE;
        end
      end
      ST_WAKE: begin
        if (r_wake_cnt == '0) begin
          w_state_next = ST_RUN;
        end
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  // Outputs decode only registered state, so no input reaches an output combinationally.
  always_comb begin
    clk_en_o      = 1'b1;
    fetch_block_o = 1'b0;
    sleeping_o    = 1'b0;
    wake_ack_o    = r_wake_ack;
    case (r_state)
      ST_DRAIN: fetch_block_o = 1'b1;
      ST_SLEEP: begin
        clk_en_o      = 1'b0;
        fetch_block_o = 1'b1;
        sleeping_o    = 1'b1;
      end
      ST_WAKE:  fetch_block_o = 1'b1;
      default:  fetch_block_o = 1'b0;
    endcase
  end

`ifdef SLEEP_CTRL_PERF_EN
  logic [63:0] r_perf_cycles;
  logic [31:0] r_perf_entries;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_cycles  <= '0;
      r_perf_entries <= '0;
    end else begin
      if (r_state == ST_SLEEP) begin
        r_perf_cycles <= r_perf_cycles + 64'd1;
      end
      if ((r_state == ST_DRAIN) && (w_state_next == ST_SLEEP)) begin
        r_perf_entries <= r_perf_entries + 32'd1;
      end
    end
  end

  assign perf_sleep_cycles_o  = r_perf_cycles;
  assign perf_sleep_entries_o = r_perf_entries;
`endif

`ifndef SYNTHESIS
  a_dpend_range: assert property (@(posedge clk) disable iff (reset) !(w_dpend_unf || w_dpend_ovf))
    else $error("vx_sleep_ctrl[%0d]: dpend saturated", CORE_ID);
  a_ipend_range: assert property (@(posedge clk) disable iff (reset) !(w_ipend_unf || w_ipend_ovf))
    else $error("vx_sleep_ctrl[%0d]: ipend saturated", CORE_ID);
`endif

endmodule

// File: tb/tb_vx_sleep_ctrl.sv
// tb_vx_sleep_ctrl: directed scoreboard bench; each cycle pushes the expected
// {clk_en, fetch_block, sleeping, wake_ack} vector and a monitor compares it at negedge.
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif

module tb_vx_sleep_ctrl;

  localparam int NT = `NUM_THREADS;

  localparam logic [3:0] E_RUN = 4'b1000;
  localparam logic [3:0] E_DRN = 4'b1100;
  localparam logic [3:0] E_SLP = 4'b0110;
  localparam logic [3:0] E_WAK = 4'b1100;
  localparam logic [3:0] E_ACK = 4'b1001;

  logic          clk;
  logic          reset;
  logic          sleep_req_i;
  logic          wakeup_i;
  logic [NT-1:0] dcache_req_valid_i;
  logic [NT-1:0] dcache_req_ready_i;
  logic          dcache_rsp_valid_i;
  logic [NT-1:0] dcache_rsp_tmask_i;
  logic          dcache_rsp_ready_i;
  logic          icache_req_valid_i;
  logic          icache_req_ready_i;
  logic          icache_rsp_valid_i;
  logic          icache_rsp_ready_i;
  logic          fetch_block_o;
  logic          clk_en_o;
  logic          sleeping_o;
  logic          wake_ack_o;
`ifdef SLEEP_CTRL_PERF_EN
  logic [63:0]   perf_sleep_cycles_o;
  logic [31:0]   perf_sleep_entries_o;
`endif

  typedef struct {
    logic [3:0] outs;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_bad;

  vx_sleep_ctrl #(
    .CORE_ID    (0),
    .WAKE_DELAY (4),
    .PEND_WIDTH (6)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .sleep_req_i        (sleep_req_i),
    .wakeup_i           (wakeup_i),
    .dcache_req_valid_i (dcache_req_valid_i),
    .dcache_req_ready_i (dcache_req_ready_i),
    .dcache_rsp_valid_i (dcache_rsp_valid_i),
    .dcache_rsp_tmask_i (dcache_rsp_tmask_i),
    .dcache_rsp_ready_i (dcache_rsp_ready_i),
    .icache_req_valid_i (icache_req_valid_i),
    .icache_req_ready_i (icache_req_ready_i),
    .icache_rsp_valid_i (icache_rsp_valid_i),
    .icache_rsp_ready_i (icache_rsp_ready_i),
    .fetch_block_o      (fetch_block_o),
    .clk_en_o           (clk_en_o),
    .sleeping_o         (sleeping_o),
    .wake_ack_o         (wake_ack_o)
`ifdef SLEEP_CTRL_PERF_EN
    ,
    .perf_sleep_cycles_o  (perf_sleep_cycles_o),
    .perf_sleep_entries_o (perf_sleep_entries_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: inputs set by the caller are sampled at the next edge, the
  // expected post-edge outputs are queued, then single-cycle inputs are cleared.
  task automatic tick(input logic [3:0] exp_outs, input string name);
    exp_t e;
    @(posedge clk);
    e.outs = exp_outs;
    e.name = name;
    sb_q.push_back(e);
    #1;
    wakeup_i           = 1'b0;
    dcache_req_valid_i = '0;
    dcache_req_ready_i = '0;
    dcache_rsp_valid_i = 1'b0;
    dcache_rsp_tmask_i = '0;
    dcache_rsp_ready_i = 1'b0;
    icache_req_valid_i = 1'b0;
    icache_req_ready_i = 1'b0;
    icache_rsp_valid_i = 1'b0;
    icache_rsp_ready_i = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [3:0] act;
    if (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      act = {clk_en_o, fetch_block_o, sleeping_o, wake_ack_o};
      n_cmp++;
      if (act !== e.outs) begin
        n_bad++;
        $display("FAIL %s: got {clk_en,fetch_block,sleeping,wake_ack}=%b required %b", e.name, act, e.outs);
      end else begin
        $display("ok   %s: outputs=%b", e.name, act);
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset              = 1'b1;
    sleep_req_i        = 1'b0;
    wakeup_i           = 1'b0;
    dcache_req_valid_i = '0;
    dcache_req_ready_i = '0;
    dcache_rsp_valid_i = 1'b0;
    dcache_rsp_tmask_i = '0;
    dcache_rsp_ready_i = 1'b0;
    icache_req_valid_i = 1'b0;
    icache_req_ready_i = 1'b0;
    icache_rsp_valid_i = 1'b0;
    icache_rsp_ready_i = 1'b0;

    tick(E_RUN, "reset_a");
    tick(E_RUN, "reset_b");
    reset = 1'b0;
    for (int i = 0; i < 7; i++) tick(E_RUN, "idle_run");

    // Idle core: edge -> DRAIN next cycle, SLEEP the one after; 4-cycle wake.
    sleep_req_i = 1'b1;
    tick(E_DRN, "s1_drain");
    tick(E_SLP, "s1_sleep");
    tick(E_SLP, "s1_sleep_hold");
    wakeup_i = 1'b1;
    tick(E_WAK, "s1_wake1");
    tick(E_WAK, "s1_wake2");
    tick(E_WAK, "s1_wake3");
    tick(E_WAK, "s1_wake4");
    tick(E_ACK, "s1_wake_ack");
    tick(E_RUN, "s1_run");
    sleep_req_i = 1'b0;
    tick(E_RUN, "s1_release");

    // Three dcache threads outstanding, drained by two responses.
    dcache_req_valid_i = 4'b0111;
    dcache_req_ready_i = 4'b0111;
    tick(E_RUN, "s2_req3");
    sleep_req_i = 1'b1;
    tick(E_DRN, "s2_edge");
    tick(E_DRN, "s2_wait");
    dcache_rsp_valid_i = 1'b1;
    dcache_rsp_ready_i = 1'b1;
    dcache_rsp_tmask_i = 4'b0011;
    tick(E_DRN, "s2_rsp1");
    dcache_rsp_valid_i = 1'b1;
    dcache_rsp_tmask_i = 4'b0100;
    tick(E_DRN, "s2_rsp_noready");
    dcache_req_valid_i = 4'b1111;
    tick(E_DRN, "s2_req_noready");
    dcache_rsp_valid_i = 1'b1;
    dcache_rsp_ready_i = 1'b1;
    dcache_rsp_tmask_i = 4'b0100;
    tick(E_DRN, "s2_rsp2");
    tick(E_SLP, "s2_sleep");
    wakeup_i = 1'b1;
    tick(E_WAK, "s2_wake1");
    tick(E_WAK, "s2_wake2");
    tick(E_WAK, "s2_wake3");
    tick(E_WAK, "s2_wake4");
    tick(E_ACK, "s2_wake_ack");
    sleep_req_i = 1'b0;
    tick(E_RUN, "s2_run");

    // Wake during the drain-complete cycle aborts without an acknowledge.
    sleep_req_i = 1'b1;
    tick(E_DRN, "s3_edge");
    wakeup_i = 1'b1;
    tick(E_RUN, "s3_abort");
    tick(E_RUN, "s3_no_ack");
    sleep_req_i = 1'b0;
    tick(E_RUN, "s3_release");
    sleep_req_i = 1'b1;
    wakeup_i    = 1'b1;
    tick(E_RUN, "s3_edge_dropped");
    tick(E_RUN, "s3_level_no_edge");
    sleep_req_i = 1'b0;
    tick(E_RUN, "s3_release2");

    // Icache: a fire blocks drain; simultaneous req/rsp keeps ipend at 1.
    sleep_req_i = 1'b1;
    tick(E_DRN, "s4_edge");
    icache_req_valid_i = 1'b1;
    icache_req_ready_i = 1'b1;
    tick(E_DRN, "s4_ireq");
    icache_req_valid_i = 1'b1;
    icache_req_ready_i = 1'b1;
    icache_rsp_valid_i = 1'b1;
    icache_rsp_ready_i = 1'b1;
    tick(E_DRN, "s4_req_rsp_same");
    tick(E_DRN, "s4_ipend_held");
    icache_rsp_valid_i = 1'b1;
    icache_rsp_ready_i = 1'b1;
    tick(E_DRN, "s4_irsp");
    tick(E_SLP, "s4_sleep");

    // Reset in SLEEP with dpend=2: RUN next, and the cleared count lets the re-drain finish at once.
    dcache_req_valid_i = 4'b0011;
    dcache_req_ready_i = 4'b0011;
    tick(E_SLP, "s5_dpend2");
    reset = 1'b1;
    tick(E_RUN, "s5_reset");
    reset = 1'b0;
    tick(E_DRN, "s5_edge_after_reset");
    tick(E_SLP, "s5_sleep_dpend0");
    wakeup_i = 1'b1;
    tick(E_WAK, "s5_wake1");
    tick(E_WAK, "s5_wake2");
    tick(E_WAK, "s5_wake3");
    tick(E_WAK, "s5_wake4");
    tick(E_ACK, "s5_wake_ack");
    sleep_req_i = 1'b0;
    tick(E_RUN, "s5_run");

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain_scoreboard: %0d entries left, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
